// File: rtl/tt_um_b14_seq_divider_if.sv
// Pin bundle of the B-14 divider tile: dedicated inputs/outputs and the bidir bank.
// The driver side (bench or tile harness) uses master, the divider side uses slave.
interface tt_um_b14_seq_divider_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_b14_seq_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Handshake: a rising edge of start (uio_in[4]) while not busy launches an operation; busy stays
// high for eight enabled cycles, then done rises with the result held until the next launch.
module tt_um_b14_seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic       r_start_q;
  logic [7:0] r_w;
  logic [4:0] r_p;
  logic [2:0] r_cnt;
  logic [3:0] r_d;
  logic       r_dz_pend;
  logic [7:0] r_q;
  logic [3:0] r_r;
  logic       r_dz;

  logic       w_launch;
  logic [4:0] w_t;
  logic       w_ge;
  logic [4:0] w_p_next;
  logic [7:0] w_w_next;
  logic       w_unused;

  assign w_launch = uio_in[4] & ~r_start_q & ((r_state == S_IDLE) | (r_state == S_DONE));

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_t      = {r_p[3:0], r_w[7]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_p_next = w_ge ? (w_t - {1'b0, r_d}) : w_t;
  assign w_w_next = {r_w[6:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_w       <= 8'h00;
      r_p       <= 5'h00;
      r_cnt     <= 3'd0;
      r_d       <= 4'h0;
      r_dz_pend <= 1'b0;
      r_q       <= 8'h00;
      r_r       <= 4'h0;
      r_dz      <= 1'b0;
    end else if (ena) begin
      r_start_q <= uio_in[4];
      case (r_state)
        S_RUN: begin
          r_w   <= w_w_next;
          r_p   <= w_p_next;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
            r_q     <= r_dz_pend ? 8'hFF : w_w_next;
            r_r     <= r_dz_pend ? 4'hF  : w_p_next[3:0];
            r_dz    <= r_dz_pend;
          end
        end
        default: begin
          if (w_launch) begin
            r_state   <= S_RUN;
            r_w       <= ui_in;
            r_d       <= uio_in[3:0];
            r_p       <= 5'h00;
            r_cnt     <= 3'd0;
            r_dz_pend <= (uio_in[3:0] == 4'h0);
          end else if (r_state != S_DONE) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // sel only steers the output mux; the quotient path never sees it.
  assign uo_out  = uio_in[5] ? {r_dz, 3'b000, r_r} : r_q;
  assign uio_out = {(r_state == S_DONE), (r_state == S_RUN), 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

  // The remainder never needs bit 4 once stored, and the top bidir inputs carry nothing.
  assign w_unused = &{1'b0, uio_in[7:6], r_p[4]};

endmodule

// File: tb/tb_tt_um_b14_seq_divider.sv
// Bench for the sequential divider: directed operations plus an exhaustive nonzero-divisor sweep,
// checked by a done-triggered monitor against a queue of expected {quotient, sel=1 view}.
module tb_tt_um_b14_seq_divider;

  logic clk;
  logic rst_n;
  logic       drv_ena;
  logic [7:0] drv_n;
  logic [3:0] drv_d;
  logic       drv_start;
  logic       mon_sel;

  int n_tests;
  int n_fail;
  logic [15:0] exp_q[$];

  tt_um_b14_seq_divider_if dut_if ();

  assign dut_if.ena    = drv_ena;
  assign dut_if.ui_in  = drv_n;
  assign dut_if.uio_in = {2'b00, mon_sel, drv_start, drv_d};

  tt_um_b14_seq_divider dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (dut_if.ena),
    .ui_in   (dut_if.ui_in),
    .uio_in  (dut_if.uio_in),
    .uo_out  (dut_if.uo_out),
    .uio_out (dut_if.uio_out),
    .uio_oe  (dut_if.uio_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic busy();
    return dut_if.uio_out[6];
  endfunction

  function automatic logic done();
    return dut_if.uio_out[7];
  endfunction

  // driver tasks: issue leaves the bench at the falling edge just after the launch edge E0
  task automatic issue(input logic [7:0] n, input logic [3:0] d, input logic [15:0] e, input bit push);
    @(negedge clk);
    drv_n     = n;
    drv_d     = d;
    drv_start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    drv_start = 1'b0;
    check("busy_after_e0", int'(busy()), 1);
  endtask

  task automatic wait_done(input int exp_c);
    int c;
    c = 0;
    while (!done() && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("latency", c, exp_c);
    check("busy_at_done", int'(busy()), 0);
  endtask

  // scoreboard monitor: owns sel, reads both output views whenever done rises
  initial begin
    logic        prev_done;
    logic [7:0]  got_q;
    logic [7:0]  got_r;
    logic [15:0] e;
    prev_done = 1'b0;
    mon_sel   = 1'b0;
    forever begin
      @(negedge clk);
      if (done() && !prev_done) begin
        #1;
        got_q   = dut_if.uo_out;
        mon_sel = 1'b1;
        #1;
        got_r   = dut_if.uo_out;
        mon_sel = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quotient", int'(got_q), int'(e[15:8]));
          check("sel1_view", int'(got_r), int'(e[7:0]));
        end
      end
      prev_done = done();
    end
  end

  initial begin
    int rises;
    logic prev_busy;
    int off;
    logic [7:0] n8;
    logic [3:0] d4;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    drv_ena   = 1'b1;
    drv_n     = 8'h00;
    drv_d     = 4'h0;
    drv_start = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_uo_out", int'(dut_if.uo_out), 8'h00);
    check("reset_uio_out", int'(dut_if.uio_out), 8'h00);
    check("reset_uio_oe", int'(dut_if.uio_oe), 8'hC0);

    // basic directed vectors: {Q, {dz,000,R}}
    issue(8'd200, 4'd7, {8'h1C, 8'h04}, 1'b1);
    wait_done(8);
    issue(8'd255, 4'd1, {8'hFF, 8'h00}, 1'b1);
    check("prev_result_during_run", int'(dut_if.uo_out), 8'h1C);
    wait_done(8);
    issue(8'd13, 4'd15, {8'h00, 8'h0D}, 1'b1);
    wait_done(8);
    issue(8'd0, 4'd9, {8'h00, 8'h00}, 1'b1);
    wait_done(8);
    issue(8'h5A, 4'd0, {8'hFF, 8'h8F}, 1'b1);
    wait_done(8);

    // start held high for 20 cycles launches once
    @(negedge clk);
    drv_n     = 8'd100;
    drv_d     = 4'd3;
    drv_start = 1'b1;
    exp_q.push_back({8'h21, 8'h01});
    rises     = 0;
    prev_busy = busy();
    repeat (20) begin
      @(negedge clk);
      if (busy() && !prev_busy) rises++;
      prev_busy = busy();
    end
    drv_start = 1'b0;
    check("held_start_launches", rises, 1);
    check("held_start_done", int'(done()), 1);

    // extra start pulse mid-run is ignored; operand changes after E0 have no effect
    issue(8'd77, 4'd5, {8'h0F, 8'h02}, 1'b1);
    drv_n = 8'hFF;
    drv_d = 4'd1;
    repeat (3) @(negedge clk);
    drv_start = 1'b1;
    @(negedge clk);
    drv_start = 1'b0;
    wait_done(4);

    // ena low for three cycles stretches the run to 11 cycles
    issue(8'd250, 4'd11, {8'h16, 8'h08}, 1'b1);
    repeat (2) @(negedge clk);
    drv_ena = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_while_disabled", int'(busy()), 1);
    drv_ena = 1'b1;
    wait_done(6);

    // reset mid-run clears everything immediately, then a fresh launch works
    issue(8'd9, 4'd2, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_uo_out", int'(dut_if.uo_out), 8'h00);
    check("midrun_reset_uio_out", int'(dut_if.uio_out), 8'h00);
    check("midrun_reset_uio_oe", int'(dut_if.uio_oe), 8'hC0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd99, 4'd4, {8'h18, 8'h03}, 1'b1);
    wait_done(8);

    // back-to-back: launch at E9 drops done and raises busy on the same edge
    issue(8'd128, 4'd3, {8'h2A, 8'h02}, 1'b1);
    wait_done(8);
    drv_n     = 8'd17;
    drv_d     = 4'd2;
    drv_start = 1'b1;
    exp_q.push_back({8'h08, 8'h01});
    @(negedge clk);
    drv_start = 1'b0;
    check("b2b_done_low", int'(done()), 0);
    check("b2b_busy_high", int'(busy()), 1);
    wait_done(8);

    // sweep every nonzero divisor with every dividend, starting at a random dividend
    off = $urandom_range(0, 255);
    for (int i = 0; i < 256; i++) begin
      for (int d = 1; d < 16; d++) begin
        n8 = 8'((i + off) % 256);
        d4 = 4'(d);
        issue(n8, d4, {8'(int'(n8) / d), 8'(int'(n8) % d)}, 1'b1);
        wait_done(8);
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
